// File: rtl/target_table.sv
// target_table: active-target slot table with lowest-free allocation, coordinate clear and duplicate filtering.
// Optional per-slot aging is enabled by defining TARGET_LIFETIME_EN.
module target_table #(
  parameter int N_SLOT   = 20,
  parameter int COORD_W  = 1,
  parameter int LIFETIME = 8,
  parameter int CNT_W    = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        spawn_valid,
  output logic                        spawn_ready,
  input  logic [COORD_W-1:0]          spawn_x,
  input  logic [COORD_W-1:0]          spawn_y,
  input  logic                        clr_valid,
  input  logic [COORD_W-1:0]          clr_x,
  input  logic [COORD_W-1:0]          clr_y,
  input  logic                        tick,
  output logic [N_SLOT*COORD_W-1:0]   arr_x,
  output logic [N_SLOT*COORD_W-1:0]   arr_y,
  output logic [N_SLOT-1:0]           arr_en,
  output logic [CNT_W-1:0]            active_cnt,
  output logic                        clr_hit,
  output logic                        dup_drop,
  output logic                        expired
);
  genvar gi;

  logic [N_SLOT*COORD_W-1:0] x_reg;
  logic [N_SLOT*COORD_W-1:0] y_reg;
  logic [N_SLOT-1:0]         en_reg;
  logic [N_SLOT-1:0]         en_next;
  logic [N_SLOT-1:0]         clr_match;
  logic [N_SLOT-1:0]         dup_match;
  logic [N_SLOT-1:0]         expire;
  logic [N_SLOT-1:0]         alloc;
  logic [CNT_W-1:0]          cnt_reg;
  logic [CNT_W-1:0]          cnt_next;
  logic                      clr_hit_reg;
  logic                      dup_drop_reg;
  logic                      expired_reg;
  logic                      accept;
  logic                      write;

  assign spawn_ready = ~&en_reg;
  assign accept      = spawn_valid & spawn_ready;
  assign write       = accept & ~|dup_match;
  // Adding one to the enable vector carries through the trailing ones, isolating the lowest free slot.
  assign alloc       = ~en_reg & (en_reg + {{(N_SLOT-1){1'b0}}, 1'b1});

  for (gi = 0; gi < N_SLOT; gi++) begin : g_match
    assign clr_match[gi] = clr_valid & en_reg[gi]
                         & (x_reg[gi*COORD_W +: COORD_W] == clr_x)
                         & (y_reg[gi*COORD_W +: COORD_W] == clr_y);
    // A slot leaving this cycle cannot block a spawn at its coordinate.
    assign dup_match[gi] = en_reg[gi] & ~clr_match[gi] & ~expire[gi]
                         & (x_reg[gi*COORD_W +: COORD_W] == spawn_x)
                         & (y_reg[gi*COORD_W +: COORD_W] == spawn_y);
  end

`ifdef TARGET_LIFETIME_EN
  localparam int AGE_W = (LIFETIME > 1) ? $clog2(LIFETIME) : 1;

  for (gi = 0; gi < N_SLOT; gi++) begin : g_age
    logic [AGE_W-1:0] age_reg;

    assign expire[gi] = tick & en_reg[gi] & (age_reg == AGE_W'(LIFETIME - 1));

    always_ff @(posedge clk) begin
      if (rst) begin
        age_reg <= '0;
      end else if (write & alloc[gi]) begin
        age_reg <= '0;
      end else if (tick & en_reg[gi]) begin
        age_reg <= age_reg + 1'b1;
      end
    end
  end
`else
  localparam int unused_lifetime = LIFETIME;
  logic unused_tick;
  assign unused_tick = tick;
  assign expire      = '0;
`endif

  assign en_next = (en_reg & ~(clr_match | expire)) | (write ? alloc : '0);

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < N_SLOT; i++) begin
      cnt_next = cnt_next + CNT_W'(en_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg        <= '0;
      y_reg        <= '0;
      en_reg       <= '0;
      cnt_reg      <= '0;
      clr_hit_reg  <= 1'b0;
      dup_drop_reg <= 1'b0;
      expired_reg  <= 1'b0;
    end else begin
      en_reg       <= en_next;
      cnt_reg      <= cnt_next;
      clr_hit_reg  <= |clr_match;
      dup_drop_reg <= accept & |dup_match;
      // A slot both cleared and aged out is reported as a hit only.
      expired_reg  <= |(expire & ~clr_match);
      for (int i = 0; i < N_SLOT; i++) begin
        if (write & alloc[i]) begin
          x_reg[i*COORD_W +: COORD_W] <= spawn_x;
          y_reg[i*COORD_W +: COORD_W] <= spawn_y;
        end
      end
    end
  end

  assign arr_x      = x_reg;
  assign arr_y      = y_reg;
  assign arr_en     = en_reg;
  assign active_cnt = cnt_reg;
  assign clr_hit    = clr_hit_reg;
  assign dup_drop   = dup_drop_reg;
  assign expired    = expired_reg;

endmodule
